// File: rtl/sirv_mrom_icb_slice_pkg.sv
// Shared helpers for the mask-ROM ICB register slice.
// Holds the credit rule used by the slice top.
package sirv_mrom_icb_slice_pkg;

    // A new command may go out only while every in-flight command
    // and every queued response still fits in the response FIFO.
    function automatic logic has_credit(
        input int unsigned outs,
        input int unsigned used,
        input int unsigned depth
    );
        return (outs + used) < depth;
    endfunction

endpackage

// File: rtl/sirv_gnrl_fifo.sv
// General-purpose shift-register FIFO with a registered head entry.
// Entry 0 is always the head, so the output comes straight from flops.
module sirv_gnrl_fifo #(
    parameter int DP = 2,
    parameter int DW = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_vld,
    input  logic [DW-1:0]              i_dat,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [DW-1:0]              o_dat,
    output logic [$clog2(DP+1)-1:0]    cnt
);

    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] mem     [DP];
    logic [DW-1:0] mem_nxt [DP];
    logic          push;
    logic          pop;
    logic [CW-1:0] wr_idx;

    assign push   = i_vld;
    assign pop    = o_vld & o_rdy;
    assign o_vld  = (cnt != '0);
    assign o_dat  = mem[0];
    // A push in a popping cycle lands one slot lower because of the shift.
    assign wr_idx = pop ? (cnt - CW'(1)) : cnt;

    // Next storage image: shift towards the head on pop, then write the push.
    always_comb begin
        for (int i = 0; i < DP; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop) begin
            for (int i = 0; i < DP - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            mem_nxt[DP-1] = '0;
        end
        for (int i = 0; i < DP; i++) begin
            if (push && (CW'(i) == wr_idx)) begin
                mem_nxt[i] = i_dat;
            end
        end
    end

    // Storage and occupancy registers; all entries clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DP; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DP; i++) begin
                mem[i] <= mem_nxt[i];
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (!push && pop) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sirv_mrom_icb_slice.sv
// ICB register slice in front of the mask-ROM controller.
// Registers responses in a FIFO and gates commands with a credit count.
module sirv_mrom_icb_slice
    import sirv_mrom_icb_slice_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [AW-1:0] i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          i_icb_rsp_err,
    output logic [DW-1:0] i_icb_rsp_rdata,
    output logic          o_icb_cmd_valid,
    input  logic          o_icb_cmd_ready,
    output logic [AW-1:0] o_icb_cmd_addr,
    output logic          o_icb_cmd_read,
    input  logic          o_icb_rsp_valid,
    output logic          o_icb_rsp_ready,
    input  logic          o_icb_rsp_err,
    input  logic [DW-1:0] o_icb_rsp_rdata
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          credit_ok;
    logic          cmd_hs;
    logic          rsp_hs;
    logic [CW-1:0] outs_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [DW:0]   head;

    // Registered counts only: a pop this cycle frees credit next cycle,
    // which keeps the ready path free of any loop through the slave.
    assign credit_ok = has_credit(32'(outs_cnt), 32'(fifo_cnt), DEPTH);

    assign o_icb_cmd_valid = i_icb_cmd_valid & credit_ok;
    assign i_icb_cmd_ready = o_icb_cmd_ready & credit_ok;
    assign o_icb_cmd_addr  = i_icb_cmd_addr;
    assign o_icb_cmd_read  = i_icb_cmd_read;
    assign cmd_hs          = o_icb_cmd_valid & o_icb_cmd_ready;

    // Credit reserves a FIFO slot for every response, so never stall it.
    assign o_icb_rsp_ready = 1'b1;
    assign rsp_hs          = o_icb_rsp_valid;

    // Outstanding count; a same-cycle command and response cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_cnt <= '0;
        end else if (cmd_hs && !rsp_hs) begin
            outs_cnt <= outs_cnt + CW'(1);
        end else if (!cmd_hs && rsp_hs) begin
            outs_cnt <= outs_cnt - CW'(1);
        end
    end

    sirv_gnrl_fifo #(
        .DP (DEPTH),
        .DW (DW + 1)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (rsp_hs),
        .i_dat ({o_icb_rsp_err, o_icb_rsp_rdata}),
        .o_vld (i_icb_rsp_valid),
        .o_rdy (i_icb_rsp_ready),
        .o_dat (head),
        .cnt   (fifo_cnt)
    );

    assign i_icb_rsp_err   = head[DW];
    assign i_icb_rsp_rdata = head[DW-1:0];

endmodule

// File: tb/tb_sirv_mrom_icb_slice.sv
// Bench for the mask-ROM ICB slice: DEPTH=2 and DEPTH=1 instances.
// Expected responses are queued on command acceptance and popped by monitors.
module tb_sirv_mrom_icb_slice;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic lat_mode;

    exp_t q[$];
    exp_t q1[$];

    // DEPTH=2 instance signals
    logic        c_valid, c_ready, c_read;
    logic [11:0] c_addr;
    logic        r_valid, r_ready, r_err;
    logic [31:0] r_rdata;
    logic        m_cvalid, m_cready, m_read;
    logic [11:0] m_addr;
    logic        m_rvalid, m_rready, m_rerr;
    logic [31:0] m_rdata;

    // DEPTH=1 instance signals
    logic        c1_valid, c1_ready, c1_read;
    logic [11:0] c1_addr;
    logic        r1_valid, r1_ready, r1_err;
    logic [31:0] r1_rdata;
    logic        m1_cvalid, m1_cready, m1_read;
    logic [11:0] m1_addr;
    logic        m1_rvalid, m1_rready, m1_rerr;
    logic [31:0] m1_rdata;

    // 3-cycle latency slave pipeline
    logic [2:0]  lv;
    logic [32:0] ld [3];

    sirv_mrom_icb_slice #(.AW(12), .DW(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(c_valid), .i_icb_cmd_ready(c_ready),
        .i_icb_cmd_addr(c_addr), .i_icb_cmd_read(c_read),
        .i_icb_rsp_valid(r_valid), .i_icb_rsp_ready(r_ready),
        .i_icb_rsp_err(r_err), .i_icb_rsp_rdata(r_rdata),
        .o_icb_cmd_valid(m_cvalid), .o_icb_cmd_ready(m_cready),
        .o_icb_cmd_addr(m_addr), .o_icb_cmd_read(m_read),
        .o_icb_rsp_valid(m_rvalid), .o_icb_rsp_ready(m_rready),
        .o_icb_rsp_err(m_rerr), .o_icb_rsp_rdata(m_rdata)
    );

    sirv_mrom_icb_slice #(.AW(12), .DW(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(c1_valid), .i_icb_cmd_ready(c1_ready),
        .i_icb_cmd_addr(c1_addr), .i_icb_cmd_read(c1_read),
        .i_icb_rsp_valid(r1_valid), .i_icb_rsp_ready(r1_ready),
        .i_icb_rsp_err(r1_err), .i_icb_rsp_rdata(r1_rdata),
        .o_icb_cmd_valid(m1_cvalid), .o_icb_cmd_ready(m1_cready),
        .o_icb_cmd_addr(m1_addr), .o_icb_cmd_read(m1_read),
        .o_icb_rsp_valid(m1_rvalid), .o_icb_rsp_ready(m1_rready),
        .o_icb_rsp_err(m1_rerr), .o_icb_rsp_rdata(m1_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return 32'h0000_00A0 + {22'd0, a[11:2]};
    endfunction

    // Latency slave: three register stages between command and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lv <= '0;
            for (int i = 0; i < 3; i++) ld[i] <= '0;
        end else begin
            lv    <= {lv[1:0], m_cvalid & m_cready & lat_mode};
            ld[0] <= {~m_read, m_read ? rom_word(m_addr) : 32'd0};
            ld[1] <= ld[0];
            ld[2] <= ld[1];
        end
    end

    // Slave in front of the DEPTH=2 slice: zero-latency ROM or latency model.
    assign m_cready = 1'b1;
    always_comb begin
        m_rvalid = m_cvalid;
        m_rerr   = ~m_read;
        m_rdata  = m_read ? rom_word(m_addr) : 32'd0;
        if (lat_mode) begin
            m_rvalid = lv[2];
            m_rerr   = ld[2][32];
            m_rdata  = ld[2][31:0];
        end
    end

    // Zero-latency ROM in front of the DEPTH=1 slice.
    assign m1_cready = 1'b1;
    assign m1_rvalid = m1_cvalid;
    assign m1_rerr   = ~m1_read;
    assign m1_rdata  = m1_read ? rom_word(m1_addr) : 32'd0;
    assign r1_ready  = 1'b1;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for the DEPTH=2 slice: in-order data, latency, protocol.
    always @(negedge clk) begin
        if (rst_n) begin
            if (r_valid && r_ready) begin
                if (q.size() == 0) begin
                    check(0, "unexpected_rsp", r_rdata, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check({r_err, r_rdata} === {e.err, e.data}, "rsp_data",
                          {r_err, r_rdata}, {e.err, e.data});
                    if (e.lat >= 0)
                        check(cyc == e.acc + e.lat, "rsp_cycle",
                              cyc, e.acc + e.lat);
                end
            end
            if (m_rvalid)
                check((dut.outs_cnt != 0) || (m_cvalid && m_cready),
                      "rsp_without_cmd", dut.outs_cnt, 1);
            if (lat_mode)
                check(dut.outs_cnt <= 2, "outs_limit", dut.outs_cnt, 2);
        end
    end

    // Monitor for the DEPTH=1 slice.
    always @(negedge clk) begin
        if (rst_n && r1_valid) begin
            if (q1.size() == 0) begin
                check(0, "d1_unexpected_rsp", r1_rdata, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check({r1_err, r1_rdata} === {e.err, e.data}, "d1_rsp_data",
                      {r1_err, r1_rdata}, {e.err, e.data});
                check(cyc == e.acc + e.lat, "d1_rsp_cycle",
                      cyc, e.acc + e.lat);
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog actual=%0d required=<20000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic send(input logic [11:0] a, input logic rd,
                        input logic ee, input logic [31:0] ed, input int lat);
        bit done;
        done    = 1'b0;
        c_valid = 1'b1;
        c_addr  = a;
        c_read  = rd;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (c_ready) begin
                q.push_back('{ee, ed, cyc, lat});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        c_valid = 1'b0;
        check(done, "send_accept", done, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q.size() != 0 || q1.size() != 0); k++)
            @(posedge clk);
        #1;
        check(q.size() == 0, "drain", q.size(), 0);
        check(q1.size() == 0, "d1_drain", q1.size(), 0);
    endtask

    initial begin
        int prev;
        int n1;
        rst_n    = 1'b0;
        lat_mode = 1'b0;
        c_valid  = 1'b0; c_addr = '0; c_read = 1'b1; r_ready = 1'b1;
        c1_valid = 1'b0; c1_addr = '0; c1_read = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(r_valid == 1'b0, "rst_rsp_valid", r_valid, 0);
        check(r_err == 1'b0, "rst_rsp_err", r_err, 0);
        check(r_rdata == 32'd0, "rst_rsp_rdata", r_rdata, 0);
        check(c_ready == 1'b1, "rst_cmd_ready", c_ready, 1);
        check(dut.outs_cnt == 0, "rst_outs_cnt", dut.outs_cnt, 0);
        check(dut.fifo_cnt == 0, "rst_fifo_cnt", dut.fifo_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back reads, one response per cycle
        send(12'h000, 1'b1, 1'b0, 32'h0000_00A0, 1);
        send(12'h004, 1'b1, 1'b0, 32'h0000_00A1, 1);
        send(12'h008, 1'b1, 1'b0, 32'h0000_00A2, 1);
        drain();

        // backpressure: two accepted, third blocked until after first pop
        r_ready = 1'b0;
        send(12'h000, 1'b1, 1'b0, 32'h0000_00A0, -1);
        send(12'h004, 1'b1, 1'b0, 32'h0000_00A1, -1);
        c_valid = 1'b1; c_addr = 12'h008; c_read = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check(c_ready == 1'b0, "bp_cmd_ready", c_ready, 0);
            check(m_cvalid == 1'b0, "bp_o_cmd_valid", m_cvalid, 0);
            check(r_valid && r_rdata == 32'h0000_00A0, "bp_head_hold",
                  r_rdata, 32'h0000_00A0);
            @(posedge clk);
            #1;
        end
        r_ready = 1'b1;
        @(negedge clk);
        check(c_ready == 1'b0, "full_with_pop", c_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check(c_ready == 1'b1, "third_accept", c_ready, 1);
        if (c_ready) q.push_back('{1'b0, 32'h0000_00A2, cyc, -1});
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        drain();

        // write returns err from the ROM
        send(12'h010, 1'b0, 1'b1, 32'h0000_0000, 1);
        drain();

        // 3-cycle latency slave: response 4 cycles after acceptance
        lat_mode = 1'b1;
        send(12'h020, 1'b1, 1'b0, 32'h0000_00A8, 4);
        send(12'h024, 1'b1, 1'b0, 32'h0000_00A9, 4);
        send(12'h028, 1'b1, 1'b0, 32'h0000_00AA, 4);
        send(12'h02C, 1'b1, 1'b0, 32'h0000_00AB, 4);
        drain();
        lat_mode = 1'b0;

        // reset while two responses are queued
        r_ready = 1'b0;
        send(12'h000, 1'b1, 1'b0, 32'h0000_00A0, -1);
        send(12'h004, 1'b1, 1'b0, 32'h0000_00A1, -1);
        @(negedge clk);
        check(dut.fifo_cnt == 2, "pre_rst_fifo_cnt", dut.fifo_cnt, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check(r_valid == 1'b0, "mid_rst_rsp_valid", r_valid, 0);
        check(dut.outs_cnt == 0, "mid_rst_outs_cnt", dut.outs_cnt, 0);
        check(dut.fifo_cnt == 0, "mid_rst_fifo_cnt", dut.fifo_cnt, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        r_ready = 1'b1;
        send(12'h00C, 1'b1, 1'b0, 32'h0000_00A3, 1);
        drain();

        // DEPTH=1: continuous reads, one accepted every other cycle
        c1_valid = 1'b1;
        prev     = -1;
        n1       = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (c1_ready) begin
                q1.push_back('{1'b0, 32'h0000_00A0 + 32'(n1), cyc, 1});
                if (prev >= 0)
                    check(cyc - prev == 2, "d1_accept_gap", cyc - prev, 2);
                prev = cyc;
                n1++;
                @(posedge clk);
                #1;
                c1_addr = c1_addr + 12'd4;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        c1_valid = 1'b0;
        check(n1 == 12, "d1_accept_count", n1, 12);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
